// File: rtl/mastermind_solver.sv
// Mastermind codebreaker. Presents 12-bit guesses (4 digits x 3 bits, digit1 in [2:0]),
// records red/white feedback in a small history and searches upward for the lowest
// code that would have produced every recorded score.
module mastermind_solver #(
    parameter int          MAX_GUESSES = 8,
    parameter logic [11:0] FIRST_GUESS = 12'o0011
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic [11:0] guess,
    output logic        guess_valid,
    input  logic        guess_ack,
    input  logic        fb_valid,
    input  logic [2:0]  fb_red,
    input  logic [2:0]  fb_white,
    output logic        busy,
    output logic        solved,
    output logic        failed,
    output logic [3:0]  guess_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT_FB,
        S_SEARCH,
        S_DONE
    } state_t;

    // History depth is fixed at 16 so a 4-bit index always addresses it cleanly;
    // entries at or above MAX_GUESSES are never written.
    localparam int HIST_DEPTH = 16;

    state_t      state_reg;
    logic [11:0] guess_reg;
    logic [11:0] cand_reg;
    logic [3:0]  h_reg;
    logic [3:0]  count_reg;
    logic        guess_valid_reg;
    logic        busy_reg;
    logic        solved_reg;
    logic        failed_reg;

    // Each entry packs {guess[11:0], red[2:0], white[2:0]}.
    logic [17:0] hist_entry [HIST_DEPTH];

    logic        start_accept;
    logic        hist_we;
    logic [3:0]  wr_idx;
    logic [17:0] hist_sel;
    logic [5:0]  cand_score;
    logic        cand_match;
    logic [3:0]  fb_sum;
    logic        fb_impossible;

    // Red = exact position matches; white = shared colours (multiset) minus red.
    function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
        logic [2:0] red;
        logic [2:0] common;
        logic [2:0] cnt_a;
        logic [2:0] cnt_b;
        red    = '0;
        common = '0;
        for (int i = 0; i < 4; i++) begin
            if (a[3*i +: 3] == b[3*i +: 3]) begin
                red = red + 3'd1;
            end
        end
        for (int c = 0; c < 8; c++) begin
            cnt_a = '0;
            cnt_b = '0;
            for (int i = 0; i < 4; i++) begin
                if (a[3*i +: 3] == 3'(c)) cnt_a = cnt_a + 3'd1;
                if (b[3*i +: 3] == 3'(c)) cnt_b = cnt_b + 3'd1;
            end
            common = common + ((cnt_a < cnt_b) ? cnt_a : cnt_b);
        end
        return {red, common - red};
    endfunction

    // Control strobes and the candidate check against the history entry under test.
    always_comb begin
        start_accept  = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
        hist_we       = (state_reg == S_WAIT_FB) && fb_valid;
        wr_idx        = count_reg - 4'd1;
        hist_sel      = hist_entry[h_reg];
        cand_score    = score(cand_reg, hist_sel[17:6]);
        cand_match    = (cand_score == hist_sel[5:0]);
        fb_sum        = {1'b0, fb_red} + {1'b0, fb_white};
        fb_impossible = (fb_sum > 4'd4) || ((fb_red == 3'd3) && (fb_white == 3'd1));
    end

    // History storage: one register per entry, cleared on reset and at game start.
    generate
        for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
            // Capture the scored guess into its slot when feedback arrives.
            always_ff @(posedge clk) begin
                if (!resetn || start_accept) begin
                    hist_entry[gi] <= '0;
                end else if (hist_we && (wr_idx == 4'(gi))) begin
                    hist_entry[gi] <= {guess_reg, fb_red, fb_white};
                end
            end
        end
    endgenerate

    // Main game FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            guess_reg       <= '0;
            cand_reg        <= '0;
            h_reg           <= '0;
            count_reg       <= '0;
            guess_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            solved_reg      <= 1'b0;
            failed_reg      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start_accept) begin
                        guess_reg       <= FIRST_GUESS;
                        cand_reg        <= FIRST_GUESS;
                        h_reg           <= '0;
                        count_reg       <= '0;
                        solved_reg      <= 1'b0;
                        failed_reg      <= 1'b0;
                        guess_valid_reg <= 1'b1;
                        busy_reg        <= 1'b1;
                        state_reg       <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (guess_ack) begin
                        count_reg       <= count_reg + 4'd1;
                        guess_valid_reg <= 1'b0;
                        state_reg       <= S_WAIT_FB;
                    end
                end
                S_WAIT_FB: begin
                    if (fb_valid) begin
                        if (fb_red == 3'd4) begin
                            solved_reg <= 1'b1;
                            busy_reg   <= 1'b0;
                            state_reg  <= S_DONE;
                        end else if (fb_impossible || (count_reg == 4'(MAX_GUESSES))) begin
                            failed_reg <= 1'b1;
                            busy_reg   <= 1'b0;
                            state_reg  <= S_DONE;
                        end else begin
                            // Every code up to the current guess is already ruled out.
                            cand_reg  <= guess_reg + 12'd1;
                            h_reg     <= '0;
                            state_reg <= S_SEARCH;
                        end
                    end
                end
                S_SEARCH: begin
                    if (!cand_match) begin
                        if (cand_reg == 12'o7777) begin
                            failed_reg <= 1'b1;
                            busy_reg   <= 1'b0;
                            state_reg  <= S_DONE;
                        end else begin
                            cand_reg <= cand_reg + 12'd1;
                            h_reg    <= '0;
                        end
                    end else if (h_reg == (count_reg - 4'd1)) begin
                        guess_reg       <= cand_reg;
                        guess_valid_reg <= 1'b1;
                        state_reg       <= S_PRESENT;
                    end else begin
                        h_reg <= h_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign guess       = guess_reg;
    assign guess_valid = guess_valid_reg;
    assign busy        = busy_reg;
    assign solved      = solved_reg;
    assign failed      = failed_reg;
    assign guess_count = count_reg;

endmodule

// File: tb/tb_mastermind_solver.sv
// Bench for mastermind_solver: directed openings plus randomized games scored by a
// behavioural model that enumerates codes and scores them digit by digit.
module tb_mastermind_solver;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        guess_ack = 1'b0;
    logic        fb_valid = 1'b0;
    logic [2:0]  fb_red = 3'd0;
    logic [2:0]  fb_white = 3'd0;

    logic [11:0] guess;
    logic        guess_valid;
    logic        busy;
    logic        solved;
    logic        failed;
    logic [3:0]  guess_count;

    logic [11:0] guess2;
    logic        guess_valid2;
    logic        busy2;
    logic        solved2;
    logic        failed2;
    logic [3:0]  guess_count2;

    int checks = 0;
    int failures = 0;

    int hq_g[$];
    int hq_r[$];
    int hq_w[$];

    mastermind_solver #(.MAX_GUESSES(8), .FIRST_GUESS(12'o0011)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .guess(guess), .guess_valid(guess_valid), .guess_ack(guess_ack),
        .fb_valid(fb_valid), .fb_red(fb_red), .fb_white(fb_white),
        .busy(busy), .solved(solved), .failed(failed), .guess_count(guess_count)
    );

    // Same stimulus, shorter guess limit: it must give up after the second score.
    mastermind_solver #(.MAX_GUESSES(2), .FIRST_GUESS(12'o0011)) dut2 (
        .clk(clk), .resetn(resetn), .start(start),
        .guess(guess2), .guess_valid(guess_valid2), .guess_ack(guess_ack),
        .fb_valid(fb_valid), .fb_red(fb_red), .fb_white(fb_white),
        .busy(busy2), .solved(solved2), .failed(failed2), .guess_count(guess_count2)
    );

    always #5 clk = ~clk;

    initial begin
        #990000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d (o%0o) exp=%0d (o%0o)", tag, got, got, exp, exp);
        end
    endtask

    // Reference scoring: exact digits first, then greedy pairing of equal colours.
    function automatic void ref_score(input int a, input int b, output int r, output int w);
        int  da[4];
        int  db[4];
        bit  used[4];
        int  common;
        r = 0;
        common = 0;
        for (int i = 0; i < 4; i++) begin
            da[i] = (a >> (3 * i)) & 7;
            db[i] = (b >> (3 * i)) & 7;
            used[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) if (da[i] == db[i]) r++;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!used[j] && db[j] == da[i]) begin
                    used[j] = 1'b1;
                    common++;
                    break;
                end
            end
        end
        w = common - r;
    endfunction

    function automatic bit consistent(input int code);
        int r;
        int w;
        for (int k = 0; k < hq_g.size(); k++) begin
            ref_score(code, hq_g[k], r, w);
            if (r != hq_r[k] || w != hq_w[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Lowest consistent code strictly after the last guess (12-bit wrap), or -1.
    function automatic int next_guess(input int last);
        for (int c = (last + 1) % 4096; c < 4096; c++) begin
            if (consistent(c)) return c;
        end
        return -1;
    endfunction

    // All stimulus tasks are entered and left on a falling edge.
    task automatic do_reset();
        resetn = 1'b0;
        start = 1'b0;
        guess_ack = 1'b0;
        fb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_ack();
        guess_ack = 1'b1;
        @(negedge clk);
        guess_ack = 1'b0;
    endtask

    task automatic do_fb(input int r, input int w);
        fb_red = 3'(r);
        fb_white = 3'(w);
        fb_valid = 1'b1;
        @(negedge clk);
        fb_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (guess_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_settle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            if (!busy || guess_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_guess"}, int'(guess), 0);
        check({tag, "_valid"}, int'(guess_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_solved"}, int'(solved), 0);
        check({tag, "_failed"}, int'(failed), 0);
        check({tag, "_count"}, int'(guess_count), 0);
    endtask

    // mode 0: feedback from scoring against secret; mode 1: random legal feedback.
    task automatic play_game(input int mode, input int secret, input bit must_solve);
        int exp;
        int r;
        int w;
        bit ok;
        bit ended;
        do_reset();
        hq_g.delete();
        hq_r.delete();
        hq_w.delete();
        pulse_start();
        exp = 12'o0011;
        ended = 1'b0;
        for (int n = 1; n <= 8 && !ended; n++) begin
            wait_valid(ok);
            check("guess_offered", int'(ok), 1);
            if (!ok) break;
            check("guess", int'(guess), exp);
            check("guess_consistent", int'(consistent(int'(guess))), 1);
            do_ack();
            check("count_after_ack", int'(guess_count), n);
            check("valid_after_ack", int'(guess_valid), 0);
            if (mode == 0) begin
                ref_score(exp, secret, r, w);
            end else begin
                r = int'($urandom_range(3, 0));
                w = int'($urandom_range(4 - r, 0));
                if (r == 3) w = 0;
            end
            $display("game mode=%0d secret=%04o n=%0d guess=%04o fb=%0d/%0d", mode, secret, n, exp, r, w);
            do_fb(r, w);
            hq_g.push_back(exp);
            hq_r.push_back(r);
            hq_w.push_back(w);
            if (r == 4) begin
                check("solved", int'(solved), 1);
                check("solved_busy", int'(busy), 0);
                check("solved_failed", int'(failed), 0);
                ended = 1'b1;
            end else begin
                if (n == 2) begin
                    check("lim2_failed", int'(failed2), 1);
                    check("lim2_count", int'(guess_count2), 2);
                    check("lim2_solved", int'(solved2), 0);
                end
                if (n == 8) begin
                    check("limit_failed", int'(failed), 1);
                    check("limit_busy", int'(busy), 0);
                    ended = 1'b1;
                end else begin
                    exp = next_guess(exp);
                    if (exp < 0) begin
                        wait_settle(ok);
                        check("exhaust_settle", int'(ok), 1);
                        check("exhaust_failed", int'(failed), 1);
                        check("exhaust_valid", int'(guess_valid), 0);
                        ended = 1'b1;
                    end
                end
            end
        end
        if (must_solve) check("must_solve", int'(solved), 1);
    endtask

    initial begin
        bit ok;
        @(negedge clk);
        do_reset();
        check_all_zero("reset");

        // Opening guess and immediate win.
        pulse_start();
        check("t1_guess", int'(guess), 12'o0011);
        check("t1_valid", int'(guess_valid), 1);
        check("t1_busy", int'(busy), 1);
        do_ack();
        do_fb(4, 0);
        $display("t1 fb=4/0 solved=%0d count=%0d", solved, guess_count);
        check("t1_solved", int'(solved), 1);
        check("t1_count", int'(guess_count), 1);
        check("t1_busy_done", int'(busy), 0);
        check("t1_failed", int'(failed), 0);

        // Feedback 1/1 on the opening guess leads to 0122.
        do_reset();
        pulse_start();
        do_ack();
        do_fb(1, 1);
        check("t2_searching", int'(busy), 1);
        check("t2_valid_low", int'(guess_valid), 0);
        wait_valid(ok);
        check("t2_offered", int'(ok), 1);
        $display("t2 fb=1/1 next=%04o", guess);
        check("t2_guess", int'(guess), 12'o0122);
        check("t2_count", int'(guess_count), 1);

        // Impossible score fails at once; new game restarts cleanly from DONE.
        do_reset();
        pulse_start();
        do_ack();
        do_fb(3, 1);
        $display("t3 fb=3/1 failed=%0d", failed);
        check("t3_failed", int'(failed), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_solved", int'(solved), 0);
        pulse_start();
        check("t3_restart_failed", int'(failed), 0);
        check("t3_restart_count", int'(guess_count), 0);
        check("t3_restart_valid", int'(guess_valid), 1);
        do_ack();
        do_fb(2, 2);
        wait_valid(ok);
        $display("t3 fb=2/2 next=%04o", guess);
        check("t3_22_guess", int'(guess), 12'o0101);
        do_reset();
        pulse_start();
        do_ack();
        do_fb(0, 0);
        wait_valid(ok);
        $display("t3 fb=0/0 next=%04o", guess);
        check("t3_00_guess", int'(guess), 12'o2222);

        // Full games.
        play_game(0, 12'o3210, 1'b1);
        for (int g = 0; g < 3; g++) play_game(0, int'($urandom_range(4095, 0)), 1'b0);
        play_game(1, 0, 1'b0);

        // Stall: guess held, stray feedback ignored; then reset mid-search.
        do_reset();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            fb_red = 3'd4;
            fb_valid = (i == 4);
            @(negedge clk);
            check("t6_hold_valid", int'(guess_valid), 1);
            check("t6_hold_guess", int'(guess), 12'o0011);
        end
        fb_valid = 1'b0;
        check("t6_hold_solved", int'(solved), 0);
        check("t6_hold_count", int'(guess_count), 0);
        do_ack();
        do_fb(1, 1);
        @(negedge clk);
        @(negedge clk);
        check("t6_mid_search", int'(busy), 1);
        resetn = 1'b0;
        @(negedge clk);
        $display("t6 reset mid-search guess=%04o busy=%0d", guess, busy);
        check_all_zero("t6_reset");
        resetn = 1'b1;
        pulse_start();
        check("t6_after_reset_valid", int'(guess_valid), 1);
        check("t6_after_reset_guess", int'(guess), 12'o0011);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
